digit_serial_addsub: RTL

DIGIT_SERIAL_ADDSUB -- requirements
Module: digit_serial_addsub

---
 rtl/digit_serial_addsub_if.sv | 10 +
 rtl/digit_serial_addsub.sv | 67 ++++++
 2 files changed

// File: rtl/digit_serial_addsub_if.sv
// digit_serial_addsub_if: input digit handshake and registered result digit bus
interface digit_serial_addsub_if #(parameter int DIGIT_W = 4);
  logic               in_valid, in_ready, sub;
  logic [DIGIT_W-1:0] a, b, sum;
  logic               out_valid, out_ready, out_last, carry_out, overflow;
  modport master (output in_valid, a, b, sub, out_ready,
                  input  in_ready, out_valid, sum, out_last, carry_out, overflow);
  modport slave  (input  in_valid, a, b, sub, out_ready,
                  output in_ready, out_valid, sum, out_last, carry_out, overflow);
endinterface

// File: rtl/digit_serial_addsub.sv
// digit_serial_addsub: LS-digit-first add/sub of multi-digit words; subtract only with DIGIT_SERIAL_ADDSUB_SUB_EN
module digit_serial_addsub #(
  parameter int DIGIT_W     = 4,
  parameter int WORD_DIGITS = 8
) (
  input logic                  clk,
  input logic                  rst,
  digit_serial_addsub_if.slave bus
);
  localparam int CW = WORD_DIGITS > 1 ? $clog2(WORD_DIGITS) : 1;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               carry_q, valid_q, last_q, cout_q, ovf_q;
  logic [DIGIT_W-1:0] sum_q, s, b_eff;
  logic [DIGIT_W:0]   c;
  logic               first, last, mode, accept;
  assign bus.in_ready  = ~valid_q | bus.out_ready;
  assign accept        = bus.in_valid & bus.in_ready;
  assign first         = cnt_q == '0;
  assign last          = cnt_q == CW'(WORD_DIGITS - 1);
  assign cnt_d         = last ? '0 : cnt_q + CW'(1);
  assign bus.out_valid = valid_q;
  assign bus.sum       = sum_q;
  assign bus.out_last  = last_q;
  assign bus.carry_out = cout_q;
  assign bus.overflow  = ovf_q;
`ifdef DIGIT_SERIAL_ADDSUB_SUB_EN
  logic mode_q;
  assign mode = first ? bus.sub : mode_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) mode_q <= 1'b0;
    else if (accept & first) mode_q <= bus.sub;
`else
  logic unused_sub;
  assign mode       = 1'b0;
  assign unused_sub = bus.sub;
`endif
  // first digit of a word injects the +1 of two's-complement negation
  assign b_eff = bus.b ^ {DIGIT_W{mode}};
  assign c[0]  = first ? mode : carry_q;
  genvar i;
  generate
    for (i = 0; i < DIGIT_W; i++) begin : g_fa
      assign s[i]   = bus.a[i] ^ b_eff[i] ^ c[i];
      assign c[i+1] = (bus.a[i] & b_eff[i]) | (c[i] & (bus.a[i] ^ b_eff[i]));
    end
  endgenerate
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt_q   <= '0;
      carry_q <= 1'b0;
      valid_q <= 1'b0;
      sum_q   <= '0;
      last_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (bus.in_ready) valid_q <= bus.in_valid;
      if (accept) begin
        sum_q   <= s;
        last_q  <= last;
        cout_q  <= last & c[DIGIT_W];
        ovf_q   <= last & (c[DIGIT_W] ^ c[DIGIT_W-1]);
        carry_q <= c[DIGIT_W];
        cnt_q   <= cnt_d;
      end
    end
endmodule
